// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared definitions for the pipeline skid register. The occupancy state enum
//   lives here so the hazard/stall controller can decode the same encoding.
//
//   Contents:
//     skid_state_e  - EMPTY / BUSY / FULL occupancy state
//     OCC_W         - width of the occupancy count
//     occ_of()      - maps a state to its held-entry count (0, 1, 2)
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

   localparam int unsigned OCC_W = 2;

   // EMPTY: no entry, BUSY: main entry only, FULL: main and skid entries.
   // The encoding equals the held-entry count, but occ_of() keeps callers
   // independent of that choice.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   function automatic logic [OCC_W-1:0] occ_of(input skid_state_e st);
      logic [OCC_W-1:0] occ;
      case (st)
         ST_EMPTY: occ = 2'd0;
         ST_BUSY:  occ = 2'd1;
         ST_FULL:  occ = 2'd2;
         default:  occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   One pipeline register stage with valid/ready flow control. REG_READY
//   selects between a two-entry skid buffer (registered in_ready_o, no
//   combinational path from out_ready_i) and a single register whose
//   in_ready_o is combinational. Latency is one cycle in both modes, and
//   sustained throughput is one transfer per cycle while out_ready_i is high.
//
//   Handshake: a transfer happens on a rising clk edge exactly when valid and
//   ready are both high in that cycle. An offered payload must stay stable
//   until accepted; out_data_o is held stable while out_valid_o=1 and
//   out_ready_i=0. When nothing is held, out_data_o shows BUBBLE_VAL.
//
//   Parameters:
//     DATA_W     - payload width in bits (>= 1)
//     BUBBLE_VAL - payload shown while out_valid_o = 0 (e.g. NOP encoding)
//     REG_READY  - 1: skid mode, 0: single-register mode
//
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   asynchronous active-high reset
//     flush_i     in   discard all held entries at the next edge
//     in_valid_i  in   upstream offers in_data_i
//     in_ready_o  out  block accepts this cycle
//     in_data_i   in   upstream payload
//     out_valid_o out  out_data_o is valid
//     out_ready_i in   downstream accepts this cycle
//     out_data_o  out  payload to the next stage
//     occ_o       out  number of held entries (0..2); also the FSM state view
// -----------------------------------------------------------------------------
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int unsigned         DATA_W     = 32,
   parameter logic [DATA_W-1:0]   BUBBLE_VAL = '0,
   parameter bit                  REG_READY  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [DATA_W-1:0]   in_data_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [DATA_W-1:0]   out_data_o,
   output logic [OCC_W-1:0]    occ_o
);

   skid_state_e       state_q;
   skid_state_e       state_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] main_d;
   logic              in_fire;
   logic              out_fire;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   // Output side is common to both modes: the main entry is always the head.
   assign out_valid_o = (state_q != ST_EMPTY);
   assign out_data_o  = out_valid_o ? main_q : BUBBLE_VAL;
   assign occ_o       = occ_of(state_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end

   generate
      if (REG_READY) begin : g_skid
         logic [DATA_W-1:0] skid_q;
         logic [DATA_W-1:0] skid_d;
         logic              ready_q;

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
               ST_EMPTY: begin
                  if (in_fire) begin
                     main_d  = in_data_i;
                     state_d = ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  if (in_fire && out_fire) begin
                     main_d  = in_data_i;
                  end else if (in_fire) begin
                     // Downstream stalled: park the new word behind main.
                     skid_d  = in_data_i;
                     state_d = ST_FULL;
                  end else if (out_fire) begin
                     state_d = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  // in_ready_o is low here, so only the output can move.
                  if (out_fire) begin
                     main_d  = skid_q;
                     state_d = ST_BUSY;
                  end
               end
               default: begin
                  state_d = ST_EMPTY;
               end
            endcase
            // Flush wins over every simultaneous transfer.
            if (flush_i) begin
               state_d = ST_EMPTY;
            end
         end

         // Ready is computed from the next state and registered, so it never
         // depends combinationally on out_ready_i.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               skid_q  <= BUBBLE_VAL;
               ready_q <= 1'b1;
            end else begin
               skid_q  <= skid_d;
               ready_q <= (state_d != ST_FULL);
            end
         end

         assign in_ready_o = ready_q;

      end else begin : g_single

         // Accept when empty or when the held word leaves this same cycle.
         assign in_ready_o = ~out_valid_o | out_ready_i;

         always_comb begin
            state_d = state_q;
            main_d  = main_q;
            if (in_fire) begin
               main_d  = in_data_i;
               state_d = ST_BUSY;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
            if (flush_i) begin
               state_d = ST_EMPTY;
            end
         end

      end
   endgenerate

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Directed bench for pipe_skid_reg. One instance in skid mode and one in
//   single-register mode share clk and rst. Inputs change and outputs are
//   observed on the falling edge (plus #1 for combinational ready).
//   Status vectors pack {out_valid, occ, in_ready, out_data}.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

   localparam int unsigned DW     = 32;
   localparam logic [DW-1:0] BUBBLE = 32'h0000_0013;

   logic clk;
   logic rst;

   logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [DW-1:0] s_in_data, s_out_data;
   logic [1:0]    s_occ;

   logic          r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
   logic [DW-1:0] r_in_data, r_out_data;
   logic [1:0]    r_occ;

   logic [35:0]   s_stat, r_stat;
   assign s_stat = {s_out_valid, s_occ, s_in_ready, s_out_data};
   assign r_stat = {r_out_valid, r_occ, r_in_ready, r_out_data};

   int checks = 0;
   int errors = 0;

   pipe_skid_reg #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE), .REG_READY(1'b1)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (s_flush),
      .in_valid_i  (s_in_valid),
      .in_ready_o  (s_in_ready),
      .in_data_i   (s_in_data),
      .out_valid_o (s_out_valid),
      .out_ready_i (s_out_ready),
      .out_data_o  (s_out_data),
      .occ_o       (s_occ)
   );

   pipe_skid_reg #(.DATA_W(DW), .BUBBLE_VAL(BUBBLE), .REG_READY(1'b0)) u_single (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (r_flush),
      .in_valid_i  (r_in_valid),
      .in_ready_o  (r_in_ready),
      .in_data_i   (r_in_data),
      .out_valid_o (r_out_valid),
      .out_ready_i (r_out_ready),
      .out_data_o  (r_out_data),
      .occ_o       (r_occ)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      #1;
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL reset_skid: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      checks++;
      if (r_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL reset_single: got %h want %h", r_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL reset_release_skid: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
   endtask

   // Push 0x11, 0x22, 0x33 with downstream stalled.
   task automatic test_fill;
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'h11;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'h11}) begin
         errors++;
         $display("FAIL fill_push1: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'h11});
      end
      s_in_data = 32'h22;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd2, 1'b0, 32'h11}) begin
         errors++;
         $display("FAIL fill_push2: got %h want %h", s_stat, {1'b1, 2'd2, 1'b0, 32'h11});
      end
      s_in_data = 32'h33;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd2, 1'b0, 32'h11}) begin
         errors++;
         $display("FAIL fill_push3_held: got %h want %h", s_stat, {1'b1, 2'd2, 1'b0, 32'h11});
      end
      s_in_valid = 1'b0;
   endtask

   // Release downstream from FULL(0x11, 0x22).
   task automatic test_drain;
      s_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'h22}) begin
         errors++;
         $display("FAIL drain_second: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'h22});
      end
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL drain_empty: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL drain_stays_empty: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
   endtask

   // Back-to-back 1..100 with downstream always ready.
   task automatic test_back_to_back;
      s_out_ready = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         if (i > 1) begin
            checks++;
            if (s_stat !== {1'b1, 2'd1, 1'b1, 32'(i - 1)}) begin
               errors++;
               $display("FAIL stream_%0d: got %h want %h", i - 1, s_stat, {1'b1, 2'd1, 1'b1, 32'(i - 1)});
            end
         end
         s_in_valid = 1'b1;
         s_in_data  = 32'(i);
         @(negedge clk);
      end
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'd100}) begin
         errors++;
         $display("FAIL stream_100: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'd100});
      end
      s_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL stream_end: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
   endtask

   task automatic test_flush;
      // FULL, then flush with input offered and output ready.
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'hA1;
      @(negedge clk);
      s_in_data = 32'hA2;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd2, 1'b0, 32'hA1}) begin
         errors++;
         $display("FAIL flush_prefill: got %h want %h", s_stat, {1'b1, 2'd2, 1'b0, 32'hA1});
      end
      s_flush     = 1'b1;
      s_in_data   = 32'hA3;
      s_out_ready = 1'b1;
      @(negedge clk);
      s_flush     = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL flush_full: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      // BUSY, flush while an input is actually accepted: that word is lost.
      s_in_valid = 1'b1;
      s_in_data  = 32'hB1;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'hB1}) begin
         errors++;
         $display("FAIL flush_busy_pre: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'hB1});
      end
      s_flush   = 1'b1;
      s_in_data = 32'hB2;
      @(negedge clk);
      s_flush = 1'b0;
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL flush_busy: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      s_in_data = 32'hB3;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'hB3}) begin
         errors++;
         $display("FAIL flush_next_word: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'hB3});
      end
      s_in_valid  = 1'b0;
      s_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL flush_drain: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
   endtask

   task automatic test_single;
      r_out_ready = 1'b0;
      r_in_valid  = 1'b1;
      r_in_data   = 32'h5A;
      #1;
      checks++;
      if (r_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready_empty: got %b want 1", r_in_ready);
      end
      @(negedge clk);
      checks++;
      if (r_stat !== {1'b1, 2'd1, 1'b0, 32'h5A}) begin
         errors++;
         $display("FAIL single_load: got %h want %h", r_stat, {1'b1, 2'd1, 1'b0, 32'h5A});
      end
      r_in_data = 32'h77;
      @(negedge clk);
      checks++;
      if (r_stat !== {1'b1, 2'd1, 1'b0, 32'h5A}) begin
         errors++;
         $display("FAIL single_hold: got %h want %h", r_stat, {1'b1, 2'd1, 1'b0, 32'h5A});
      end
      r_out_ready = 1'b1;
      r_in_data   = 32'hAB;
      #1;
      checks++;
      if (r_stat !== {1'b1, 2'd1, 1'b1, 32'h5A}) begin
         errors++;
         $display("FAIL single_ready_comb: got %h want %h", r_stat, {1'b1, 2'd1, 1'b1, 32'h5A});
      end
      @(negedge clk);
      checks++;
      if (r_stat !== {1'b1, 2'd1, 1'b1, 32'hAB}) begin
         errors++;
         $display("FAIL single_ab: got %h want %h", r_stat, {1'b1, 2'd1, 1'b1, 32'hAB});
      end
      r_in_data = 32'hCD;
      @(negedge clk);
      checks++;
      if (r_stat !== {1'b1, 2'd1, 1'b1, 32'hCD}) begin
         errors++;
         $display("FAIL single_cd: got %h want %h", r_stat, {1'b1, 2'd1, 1'b1, 32'hCD});
      end
      r_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (r_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL single_empty: got %h want %h", r_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      r_in_valid = 1'b1;
      r_in_data  = 32'hE1;
      @(negedge clk);
      r_flush   = 1'b1;
      r_in_data = 32'hE2;
      @(negedge clk);
      r_flush    = 1'b0;
      r_in_valid = 1'b0;
      checks++;
      if (r_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL single_flush: got %h want %h", r_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
   endtask

   task automatic test_async_reset;
      @(negedge clk);
      s_out_ready = 1'b0;
      s_in_valid  = 1'b1;
      s_in_data   = 32'hC1;
      r_out_ready = 1'b0;
      r_in_valid  = 1'b1;
      r_in_data   = 32'hD1;
      @(negedge clk);
      s_in_valid = 1'b0;
      r_in_valid = 1'b0;
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'hC1}) begin
         errors++;
         $display("FAIL arst_pre_skid: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'hC1});
      end
      // Assert reset in the low phase; outputs must clear before any edge.
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL arst_skid: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      checks++;
      if (r_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL arst_single: got %h want %h", r_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
      @(negedge clk);
      rst        = 1'b0;
      s_in_valid = 1'b1;
      s_in_data  = 32'hC2;
      r_in_valid = 1'b1;
      r_in_data  = 32'hD2;
      @(negedge clk);
      s_in_valid = 1'b0;
      r_in_valid = 1'b0;
      checks++;
      if (s_stat !== {1'b1, 2'd1, 1'b1, 32'hC2}) begin
         errors++;
         $display("FAIL arst_first_capture_skid: got %h want %h", s_stat, {1'b1, 2'd1, 1'b1, 32'hC2});
      end
      checks++;
      if (r_stat !== {1'b1, 2'd1, 1'b0, 32'hD2}) begin
         errors++;
         $display("FAIL arst_first_capture_single: got %h want %h", r_stat, {1'b1, 2'd1, 1'b0, 32'hD2});
      end
      s_out_ready = 1'b1;
      r_out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (s_stat !== {1'b0, 2'd0, 1'b1, BUBBLE}) begin
         errors++;
         $display("FAIL arst_drain_skid: got %h want %h", s_stat, {1'b0, 2'd0, 1'b1, BUBBLE});
      end
   endtask

   initial begin
      rst         = 1'b1;
      s_flush     = 1'b0;
      s_in_valid  = 1'b0;
      s_in_data   = '0;
      s_out_ready = 1'b0;
      r_flush     = 1'b0;
      r_in_valid  = 1'b0;
      r_in_data   = '0;
      r_out_ready = 1'b0;

      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_flush();
      test_single();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pipe_skid_reg
